// File: rtl/clint_responder_if.sv
// Data-RAM request port as seen by the CLINT. The core side drives the
// request; the CLINT answers with hit and read data in the same cycle.
//
// Handshake: there is no ready signal. A transfer happens in every cycle
// where ram_req_i is high. ram_we_i selects write (committed at the next
// rising clock) or read (ram_data_o valid combinationally in that cycle).
// hit_o qualifies ram_data_o for the interconnect's RAM/CLINT data mux.
interface clint_responder_if #(
    parameter int XLEN = 32
);
    logic            ram_req_i;
    logic            ram_we_i;
    logic [XLEN-1:0] ram_addr_i;
    logic [XLEN-1:0] ram_wdata_i;
    logic [XLEN-1:0] ram_data_o;
    logic            hit_o;

    modport master (
        output ram_req_i,
        output ram_we_i,
        output ram_addr_i,
        output ram_wdata_i,
        input  ram_data_o,
        input  hit_o
    );

    modport slave (
        input  ram_req_i,
        input  ram_we_i,
        input  ram_addr_i,
        input  ram_wdata_i,
        output ram_data_o,
        output hit_o
    );
endinterface

// File: rtl/clint_responder.sv
// Core-local interruptor: 64-bit mtime with prescaler, 64-bit mtimecmp and
// msip, mapped into a 64 KiB window on the core's data-RAM port. Drives the
// core's timer and software interrupt inputs. Register map assumes XLEN=32.
module clint_responder #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] BASE_ADDR = 32'h0200_0000,
    parameter int              TICK_DIV  = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    clint_responder_if.slave   bus,
    output logic               timer_irq_o,
    output logic               software_irq_o
);
    localparam logic [15:0] OFF_MSIP     = 16'h0000;
    localparam logic [15:0] OFF_CMP_LO   = 16'h4000;
    localparam logic [15:0] OFF_CMP_HI   = 16'h4004;
    localparam logic [15:0] OFF_MTIME_LO = 16'hBFF8;
    localparam logic [15:0] OFF_MTIME_HI = 16'hBFFC;

    // A one-bit counter is kept even for TICK_DIV=1 so the width never hits zero.
    localparam int              CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] div_cnt;
    logic [CNT_W-1:0] div_nxt;
    logic             tick;
    logic [63:0]      mtime;
    logic [63:0]      mtime_nxt;
    logic [63:0]      mtimecmp;
    logic             msip;
    logic             hit;
    logic             wr_en;
    logic [15:0]      offset;
    logic [31:0]      wdata;
    logic [31:0]      rd_word;
    logic [1:0]       unused_addr_lsb;

    // Window decode; the two address LSBs are dropped so every access is a word.
    assign hit             = bus.ram_req_i && (bus.ram_addr_i[XLEN-1:16] == BASE_ADDR[XLEN-1:16]);
    assign offset          = {bus.ram_addr_i[15:2], 2'b00};
    assign unused_addr_lsb = bus.ram_addr_i[1:0];
    assign wr_en           = hit && bus.ram_we_i;
    assign wdata           = bus.ram_wdata_i[31:0];
    assign bus.hit_o       = hit;

    // Prescaler: wraps at TICK_DIV-1 and is not disturbed by mtime writes.
    assign tick    = (div_cnt == DIV_LAST);
    assign div_nxt = tick ? '0 : div_cnt + 1'b1;

    // Next mtime: a bus write to one half wins over the tick and leaves the
    // other half at its pre-increment value (no carry across the halves).
    always_comb begin
        mtime_nxt = tick ? (mtime + 64'd1) : mtime;
        if (wr_en && offset == OFF_MTIME_LO) begin
            mtime_nxt = {mtime[63:32], wdata};
        end else if (wr_en && offset == OFF_MTIME_HI) begin
            mtime_nxt = {wdata, mtime[31:0]};
        end
    end

    // Same-cycle read mux; unmapped offsets and writes return zero.
    always_comb begin
        rd_word = 32'h0;
        case (offset)
            OFF_MSIP:     rd_word = {31'h0, msip};
            OFF_CMP_LO:   rd_word = mtimecmp[31:0];
            OFF_CMP_HI:   rd_word = mtimecmp[63:32];
            OFF_MTIME_LO: rd_word = mtime[31:0];
            OFF_MTIME_HI: rd_word = mtime[63:32];
            default:      rd_word = 32'h0;
        endcase
        bus.ram_data_o = (hit && !bus.ram_we_i) ? XLEN'(rd_word) : '0;
    end

    // Register file, counter and registered interrupt level; reset beats any write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_cnt     <= '0;
            mtime       <= 64'h0;
            mtimecmp    <= {64{1'b1}};
            msip        <= 1'b0;
            timer_irq_o <= 1'b0;
        end else begin
            div_cnt     <= div_nxt;
            mtime       <= mtime_nxt;
            timer_irq_o <= (mtime >= mtimecmp);
            if (wr_en && offset == OFF_CMP_LO) begin
                mtimecmp[31:0] <= wdata;
            end
            if (wr_en && offset == OFF_CMP_HI) begin
                mtimecmp[63:32] <= wdata;
            end
            if (wr_en && offset == OFF_MSIP) begin
                msip <= wdata[0];
            end
        end
    end

    // msip is itself a flop, so the software interrupt follows the write by one edge.
    assign software_irq_o = msip;

endmodule
